foo_update_sched: RTL and testbench
===================================

# foo_update_sched

Scheduler that shares one `foo` evaluation engine between `NREQ` requesters. It arbitrates combinational-update and sequential-update requests, with sequential updates taking priority. It issues one operation at a time over a valid/ready engine port, stamps every completed result with a global sequence number, and keeps per-requester output registers. Downstream muxing therefore uses ordering, not simulation time. It sits between the per-instance black-box wrappers and the single shared model backend.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; must be at least 2.
- `SEQW`, default 16: width of the sequence counter.
- `TIMEOUT`, default 1024: number of WAIT cycles before an operation is abandoned; must be at least 1.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_op` in NREQ: per requester, 0 = comb update, 1 = seq update.
- `req_a` in NREQ*64: per-requester `a` operand; requester i occupies bits [i*64 +: 64].
- `req_long_in` in NREQ*129: per-requester `long_in` operand; requester i occupies bits [i*129 +: 129].
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `eng_valid` out 1: operation offered to the engine.
- `eng_ready` in 1: engine accepts the offered operation.
- `eng_op` out 1: operation type of the issued request.
- `eng_id` out $clog2(NREQ): index of the requester being served.
- `eng_a` out 64: `a` operand of the issued request.
- `eng_long_in` out 129: `long_in` operand of the issued request.
- `rsp_valid` in 1: engine result valid.
- `rsp_x` in 64: engine result `x`.
- `rsp_long_out` in 129: engine result `long_out`.
- `out_x` out NREQ*64: latest `x` per requester.
- `out_long_out` out NREQ*129: latest `long_out` per requester.
- `out_seq` out NREQ*SEQW: sequence stamp of each requester's latest result.
- `out_upd` out NREQ: one-cycle pulse marking the requester whose outputs were just written.
- `busy` out 1: high when the state is not IDLE.
- `timeout` out 1: sticky error flag.

## Operation
States:
- IDLE:
  - If any `req_valid` is set, grant one requester, pulse its `req_ready`, latch `req_op`/`req_a`/`req_long_in` and the index into the eng registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `eng_valid`=1; all eng outputs are held stable.
  - When `eng_ready`=1, go to WAIT and clear the wait counter.
- WAIT:
  - When `rsp_valid`=1:
    - Write `rsp_x`/`rsp_long_out` into slot `eng_id`.
    - Set `out_seq[eng_id]` = seq counter, then increment the seq counter; it wraps modulo 2^SEQW.
    - Pulse `out_upd[eng_id]` and go to IDLE.
  - Otherwise increment the wait counter. At the cycle the counter reaches TIMEOUT-1:
    - set `timeout`;
    - return to IDLE;
    - do not write any slot and do not increment the seq counter.

Arbitration:
- Requests with `req_op`=1 beat all requests with `req_op`=0.
- Within the winning class, round-robin starting at the index after the last granted requester, searching upward and wrapping at NREQ-1 → 0.
- The pointer updates only on a grant.

Other rules:
- Exactly one operation is outstanding; `rsp_valid` outside WAIT is ignored.
- A requester keeps `req_valid` and its operands stable until it sees `req_ready`.
- `timeout` clears only on `rst`.
- Consumers compare `out_seq` values with wrap-aware (serial-number) subtraction.

## Timing
- Reset values:
  - state IDLE, rr pointer = NREQ-1 (so requester 0 wins first), seq counter 0;
  - all outputs 0, including `out_*`, `eng_*`, `req_ready`, `busy` and `timeout`.
- Synchronous reset mid-operation abandons the operation: `eng_valid` and `busy` are 0 in the cycle after the reset edge, and no slot is written.
- Grant in cycle N (IDLE): `req_ready` is high in N, `eng_valid` is high from N+1.
- If `eng_ready`=1 in N+1, the state is WAIT at N+2. The earliest `rsp_valid` is at N+2, giving `out_upd`/`out_*` at N+3 and IDLE at N+3.
- Earliest next grant is N+3, so peak throughput is one operation per 3 cycles.
- `eng_ready` held low keeps the block in ISSUE indefinitely; there is no timeout in ISSUE.
- If `rsp_valid` and timeout expiry occur in the same cycle, `rsp_valid` wins: the result is written and `timeout` is not set.

## Test plan
- **Reset:** apply reset, then release → all outputs 0; on first grant with requesters 0 and 2 both comb-valid, requester 0 is served first.
- **Single comb request:** requester 1 issues a comb request with a=5; `eng_ready` returns immediately and `rsp_x`=0x2A arrives 1 cycle later → `out_x[1]`=0x2A, `out_seq[1]`=0, `out_upd`=0b0010 at N+3.
- **Priority and round-robin:** all 4 requesters hold comb requests and requester 3 adds a seq request → grant order 3, 0, 1, 2; `out_seq` values come out as 0, 1, 2, 3 in that order.
- **Timeout:** TIMEOUT=8 and `rsp_valid` withheld → `timeout`=1 after 8 WAIT cycles, no `out_upd`, seq counter unchanged; a late `rsp_valid` in IDLE is ignored.
- **Engine backpressure:** `eng_ready` held low for 10 cycles → `eng_*` stable throughout and no new `req_ready`.
- **Wrap and reset:** SEQW=2 with 5 ops → stamps 0, 1, 2, 3, 0. Separately, asserting `rst` during WAIT → `busy`=0 next cycle and no slot written.

Source files
------------

// File: rtl/foo_update_sched_if.sv
// Bundle of requester, engine and per-requester result signals around the shared
// foo engine scheduler. "master" is the scheduler side, "slave" the environment.
interface foo_update_sched_if #(
    parameter int NREQ = 4,
    parameter int SEQW = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_op;
    logic [NREQ*64-1:0]     req_a;
    logic [NREQ*129-1:0]    req_long_in;
    logic [NREQ-1:0]        req_ready;

    logic                   eng_valid;
    logic                   eng_ready;
    logic                   eng_op;
    logic [IDW-1:0]         eng_id;
    logic [63:0]            eng_a;
    logic [128:0]           eng_long_in;

    logic                   rsp_valid;
    logic [63:0]            rsp_x;
    logic [128:0]           rsp_long_out;

    logic [NREQ*64-1:0]     out_x;
    logic [NREQ*129-1:0]    out_long_out;
    logic [NREQ*SEQW-1:0]   out_seq;
    logic [NREQ-1:0]        out_upd;

    modport master (
        input  req_valid, req_op, req_a, req_long_in,
        input  eng_ready, rsp_valid, rsp_x, rsp_long_out,
        output req_ready, eng_valid, eng_op, eng_id, eng_a, eng_long_in,
        output out_x, out_long_out, out_seq, out_upd
    );

    modport slave (
        output req_valid, req_op, req_a, req_long_in,
        output eng_ready, rsp_valid, rsp_x, rsp_long_out,
        input  req_ready, eng_valid, eng_op, eng_id, eng_a, eng_long_in,
        input  out_x, out_long_out, out_seq, out_upd
    );
endinterface

// File: rtl/foo_update_sched.sv
// Shares one foo engine between NREQ requesters: seq-over-comb priority with
// round-robin inside a class, one outstanding op, sequence-stamped result slots.
module foo_update_sched #(
    parameter int NREQ    = 4,
    parameter int SEQW    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    foo_update_sched_if.master  bus,
    output logic                busy,
    output logic                timeout
);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int A_W  = 64;
    localparam int L_W  = 129;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [SEQW-1:0]   seq_cnt;
    logic [CW-1:0]     wait_cnt;

    logic [A_W-1:0]    a_in   [NREQ];
    logic [L_W-1:0]    l_in   [NREQ];
    logic [A_W-1:0]    x_reg  [NREQ];
    logic [L_W-1:0]    l_reg  [NREQ];
    logic [SEQW-1:0]   seq_reg[NREQ];
    logic [NREQ-1:0]   upd_reg;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign a_in[i] = bus.req_a[i*A_W +: A_W];
        assign l_in[i] = bus.req_long_in[i*L_W +: L_W];
        assign bus.out_x[i*A_W +: A_W]          = x_reg[i];
        assign bus.out_long_out[i*L_W +: L_W]   = l_reg[i];
        assign bus.out_seq[i*SEQW +: SEQW]      = seq_reg[i];
    end

    // Seq requests shadow comb requests entirely; round-robin runs inside the winning class.
    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [IDW-1:0]    idx;

    always_comb begin
        cand      = ((bus.req_valid & bus.req_op) != '0) ? (bus.req_valid & bus.req_op)
                                                        : bus.req_valid;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_any && cand[idx]) begin
                grant_any  = 1'b1;
                grant_id   = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
    assign bus.eng_valid = (state == ISSUE);
    assign bus.out_upd   = upd_reg;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= IDW'(NREQ - 1);
            seq_cnt         <= '0;
            wait_cnt        <= '0;
            timeout         <= 1'b0;
            bus.eng_op      <= 1'b0;
            bus.eng_id      <= '0;
            bus.eng_a       <= '0;
            bus.eng_long_in <= '0;
            upd_reg         <= '0;
            for (int i = 0; i < NREQ; i++) begin
                x_reg[i]   <= '0;
                l_reg[i]   <= '0;
                seq_reg[i] <= '0;
            end
        end else begin
            upd_reg <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.eng_op      <= bus.req_op[grant_id];
                        bus.eng_id      <= grant_id;
                        bus.eng_a       <= a_in[grant_id];
                        bus.eng_long_in <= l_in[grant_id];
                        rr_ptr          <= grant_id;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.eng_ready) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the expiry cycle still counts.
                    if (bus.rsp_valid) begin
                        x_reg[bus.eng_id]   <= bus.rsp_x;
                        l_reg[bus.eng_id]   <= bus.rsp_long_out;
                        seq_reg[bus.eng_id] <= seq_cnt;
                        seq_cnt             <= seq_cnt + 1'b1;
                        upd_reg[bus.eng_id] <= 1'b1;
                        state               <= IDLE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_foo_update_sched.sv
// Directed bench for foo_update_sched: stimulus pushes expected grants, results and
// per-cycle status into queues; a negedge monitor pops and compares.
module tb_foo_update_sched;
    localparam int NREQ    = 4;
    localparam int SEQW    = 2;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout;

    always #5 clk = ~clk;

    foo_update_sched_if #(.NREQ(NREQ), .SEQW(SEQW)) bus();

    foo_update_sched #(.NREQ(NREQ), .SEQW(SEQW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        int            id;
        logic [63:0]   x;
        logic [128:0]  l;
        logic [SEQW-1:0] seq;
    } res_t;

    typedef struct {
        string         nm;
        logic [3:0]    r;
        logic          b;
        logic          t;
        logic          e;
        logic [3:0]    u;
        bit            z;
    } stat_t;

    res_t  exp_res[$];
    int    exp_grant[$];
    stat_t exp_stat[$];

    int errors = 0;
    int checks = 0;

    bit eng_hold  = 1'b0;
    bit rsp_en    = 1'b1;
    bit rsp_force = 1'b0;
    bit done      = 1'b0;

    function automatic logic [128:0] lng(input logic [63:0] a);
        return {1'b1, ~a, a};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine model: accepts whenever not held, answers one cycle later with x=a+0x25, long=~long_in.
    initial begin
        bus.eng_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_x        = '0;
        bus.rsp_long_out = '0;
        forever begin
            @(negedge clk);
            bus.eng_ready = bus.eng_valid && !eng_hold;
            if (rsp_force || (rsp_en && busy && !bus.eng_valid)) begin
                bus.rsp_valid    = 1'b1;
                bus.rsp_x        = bus.eng_a + 64'h25;
                bus.rsp_long_out = ~bus.eng_long_in;
            end else begin
                bus.rsp_valid    = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        stat_t s;
        res_t r;
        int g;
        logic prev_ev;
        logic [255:0] prev_eng;
        logic [255:0] cur_eng;
        logic nz;
        prev_ev  = 1'b0;
        prev_eng = '0;
        forever begin
            @(negedge clk);
            if (exp_stat.size() > 0) begin
                s = exp_stat.pop_front();
                chk({s.nm, ".req_ready"}, 256'(bus.req_ready), 256'(s.r));
                chk({s.nm, ".busy"},      256'(busy),          256'(s.b));
                chk({s.nm, ".timeout"},   256'(timeout),       256'(s.t));
                chk({s.nm, ".eng_valid"}, 256'(bus.eng_valid), 256'(s.e));
                chk({s.nm, ".out_upd"},   256'(bus.out_upd),   256'(s.u));
                if (s.z) begin
                    nz = |{bus.req_ready, bus.eng_valid, bus.eng_op, bus.eng_id, bus.eng_a,
                           bus.eng_long_in, bus.out_x, bus.out_long_out, bus.out_seq,
                           bus.out_upd, busy, timeout};
                    chk({s.nm, ".any_output_nonzero"}, 256'(nz), 256'(0));
                end
            end
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", 256'(bus.req_ready), 256'(0));
                end else begin
                    g = exp_grant.pop_front();
                    chk("grant", 256'(bus.req_ready), 256'(1) << g);
                end
            end
            if (bus.out_upd != '0) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_upd", 256'(bus.out_upd), 256'(0));
                end else begin
                    r = exp_res.pop_front();
                    chk("upd_onehot",   256'(bus.out_upd), 256'(1) << r.id);
                    chk("out_x",        256'(64'(bus.out_x >> (r.id * 64))), 256'(r.x));
                    chk("out_long_out", 256'(129'(bus.out_long_out >> (r.id * 129))), 256'(r.l));
                    chk("out_seq",      256'(SEQW'(bus.out_seq >> (r.id * SEQW))), 256'(r.seq));
                end
            end
            cur_eng = 256'({bus.eng_op, bus.eng_id, bus.eng_a, bus.eng_long_in});
            if (bus.eng_valid && prev_ev)
                chk("eng_stable", cur_eng, prev_eng);
            prev_ev  = bus.eng_valid;
            prev_eng = cur_eng;
            if (done) begin
                chk("res_queue_drained",   256'(exp_res.size()),   256'(0));
                chk("grant_queue_drained", 256'(exp_grant.size()), 256'(0));
                chk("stat_queue_drained",  256'(exp_stat.size()),  256'(0));
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        logic [NREQ-1:0] gr;
        @(negedge clk);
        gr = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~gr;
    endtask

    task automatic cyc(input string nm, input logic [3:0] r, input logic b, input logic t,
                       input logic e, input logic [3:0] u, input bit z = 1'b0);
        exp_stat.push_back('{nm: nm, r: r, b: b, t: t, e: e, u: u, z: z});
        tick();
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic op, input logic [63:0] a);
        bus.req_op[i]                = op;
        bus.req_a[i*64 +: 64]        = a;
        bus.req_long_in[i*129 +: 129] = lng(a);
        bus.req_valid[i]             = 1'b1;
    endtask

    task automatic want(input int id, input logic [63:0] a, input logic [63:0] x, input int seq);
        exp_grant.push_back(id);
        exp_res.push_back('{id: id, x: x, l: ~lng(a), seq: SEQW'(seq)});
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_op      = '0;
        bus.req_a       = '0;
        bus.req_long_in = '0;

        // Reset state, then requester 0 beats requester 2 on the first grant
        reset_dut();
        cyc("reset", 4'b0000, 0, 0, 0, 4'b0000, 1'b1);
        set_req(0, 1'b0, 64'h10);
        set_req(2, 1'b0, 64'h20);
        want(0, 64'h10, 64'h35, 0);
        want(2, 64'h20, 64'h45, 1);
        cyc("first_grant", 4'b0001, 0, 0, 0, 4'b0000);
        repeat (8) tick();

        // Single comb request with exact latency
        reset_dut();
        set_req(1, 1'b0, 64'h5);
        want(1, 64'h5, 64'h2A, 0);
        cyc("single_n",  4'b0010, 0, 0, 0, 4'b0000);
        cyc("single_n1", 4'b0000, 1, 0, 1, 4'b0000);
        cyc("single_n2", 4'b0000, 1, 0, 0, 4'b0000);
        cyc("single_n3", 4'b0000, 0, 0, 0, 4'b0010);
        repeat (2) tick();

        // Seq priority then round-robin
        reset_dut();
        set_req(0, 1'b0, 64'h100);
        set_req(1, 1'b0, 64'h200);
        set_req(2, 1'b0, 64'h300);
        set_req(3, 1'b1, 64'h400);
        want(3, 64'h400, 64'h425, 0);
        want(0, 64'h100, 64'h125, 1);
        want(1, 64'h200, 64'h225, 2);
        want(2, 64'h300, 64'h325, 3);
        repeat (14) tick();

        // Timeout, late response ignored, seq counter untouched
        reset_dut();
        rsp_en = 1'b0;
        set_req(2, 1'b0, 64'h77);
        exp_grant.push_back(2);
        cyc("to_grant", 4'b0100, 0, 0, 0, 4'b0000);
        cyc("to_issue", 4'b0000, 1, 0, 1, 4'b0000);
        repeat (8) cyc("to_wait", 4'b0000, 1, 0, 0, 4'b0000);
        cyc("to_expired", 4'b0000, 0, 1, 0, 4'b0000);
        rsp_force = 1'b1;
        cyc("to_late_rsp", 4'b0000, 0, 1, 0, 4'b0000);
        rsp_force = 1'b0;
        cyc("to_ignored", 4'b0000, 0, 1, 0, 4'b0000);
        rsp_en = 1'b1;
        set_req(3, 1'b0, 64'h9);
        want(3, 64'h9, 64'h2E, 0);
        cyc("to_next", 4'b1000, 0, 1, 0, 4'b0000);
        repeat (5) tick();
        cyc("to_sticky", 4'b0000, 0, 1, 0, 4'b0000);

        // Engine backpressure
        reset_dut();
        eng_hold = 1'b1;
        set_req(0, 1'b0, 64'h11);
        set_req(1, 1'b0, 64'h22);
        want(0, 64'h11, 64'h36, 0);
        want(1, 64'h22, 64'h47, 1);
        cyc("bp_grant", 4'b0001, 0, 0, 0, 4'b0000);
        repeat (11) cyc("bp_hold", 4'b0000, 1, 0, 1, 4'b0000);
        eng_hold = 1'b0;
        cyc("bp_release", 4'b0000, 1, 0, 1, 4'b0000);
        cyc("bp_wait",    4'b0000, 1, 0, 0, 4'b0000);
        cyc("bp_done",    4'b0010, 0, 0, 0, 4'b0001);
        repeat (6) tick();

        // Sequence stamp wrap with SEQW=2
        reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, 64'(i + 1));
            want(i, 64'(i + 1), 64'(i + 'h26), i);
        end
        repeat (14) tick();
        set_req(0, 1'b0, 64'h50);
        want(0, 64'h50, 64'h75, 0);
        repeat (5) tick();

        // Reset while waiting abandons the operation
        rsp_en = 1'b0;
        set_req(1, 1'b0, 64'h3);
        exp_grant.push_back(1);
        cyc("rw_grant", 4'b0010, 0, 0, 0, 4'b0000);
        cyc("rw_issue", 4'b0000, 1, 0, 1, 4'b0000);
        cyc("rw_wait",  4'b0000, 1, 0, 0, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_en = 1'b1;
        cyc("rw_after_rst", 4'b0000, 0, 0, 0, 4'b0000, 1'b1);
        repeat (3) tick();
        done = 1'b1;
    end
endmodule
